// File: rtl/tomasulo_rob_pkg.sv
// Shared definitions for the Tomasulo reorder buffer and its CDB matchers:
// default geometry and the per-entry status flag layout.
package tomasulo_rob_pkg;

    localparam int unsigned ROB_DEF_DEPTH     = 8;
    localparam int unsigned ROB_DEF_REG_W     = 4;
    localparam int unsigned ROB_DEF_DATA_W    = 32;
    localparam int unsigned ROB_DEF_CDB_PORTS = 2;

    // Per-entry status bits; dest and value live in separate arrays.
    typedef struct packed {
        logic busy;
        logic ready;
        logic is_branch;
        logic mispredict;
    } rob_flags_t;

endpackage

// File: rtl/tomasulo_cdb_match.sv
// CDB tag matcher: finds the lowest-index valid CDB port carrying `tag`.
// Ports:
//   tag            - tag to look for
//   cdb_valid      - per-port result strobes
//   cdb_tag        - packed port tags, port 0 in the LSBs
//   cdb_value      - packed port values, port 0 in the LSBs
//   cdb_mispredict - per-port mispredict bits
//   hit_c          - some valid port carries tag
//   value_c        - value from the winning port (0 when no hit)
//   mispredict_c   - mispredict bit from the winning port (0 when no hit)
module tomasulo_cdb_match
    import tomasulo_rob_pkg::*;
#(
    parameter int unsigned TAG_W     = 3,
    parameter int unsigned DATA_W    = ROB_DEF_DATA_W,
    parameter int unsigned CDB_PORTS = ROB_DEF_CDB_PORTS
) (
    input  logic [TAG_W-1:0]            tag,
    input  logic [CDB_PORTS-1:0]        cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag,
    input  logic [CDB_PORTS*DATA_W-1:0] cdb_value,
    input  logic [CDB_PORTS-1:0]        cdb_mispredict,
    output logic                        hit_c,
    output logic [DATA_W-1:0]           value_c,
    output logic                        mispredict_c
);

    // Ascending scan; the first hit latches, so the lowest port wins.
    always_comb begin
        hit_c        = 1'b0;
        value_c      = '0;
        mispredict_c = 1'b0;
        for (int unsigned p = 0; p < CDB_PORTS; p++) begin
            if (!hit_c && cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == tag)) begin
                hit_c        = 1'b1;
                value_c      = cdb_value[p*DATA_W +: DATA_W];
                mispredict_c = cdb_mispredict[p];
            end
        end
    end

endmodule

// File: rtl/tomasulo_rob.sv
// Parametrised circular reorder buffer: in-order allocation at issue, result
// capture from any CDB port, operand forwarding, in-order commit from the
// head, and a full flush when a mispredicted branch retires.
// Ports:
//   clk1, rst_n                 - clock, async active-low reset
//   alloc_valid/dest/is_branch  - issue request; alloc_ready/alloc_tag reply
//   cdb_valid/tag/value/mispredict - CDB_PORTS packed writeback ports
//   rd_tag_a/b -> rd_ready_a/b, rd_value_a/b - operand lookups with CDB bypass
//   commit_valid/tag/dest/value/flush - head retirement (always accepted)
//   count, full, empty          - occupancy
module tomasulo_rob
    import tomasulo_rob_pkg::*;
#(
    parameter int unsigned DEPTH     = ROB_DEF_DEPTH,
    parameter int unsigned REG_W     = ROB_DEF_REG_W,
    parameter int unsigned DATA_W    = ROB_DEF_DATA_W,
    parameter int unsigned CDB_PORTS = ROB_DEF_CDB_PORTS
) (
    input  logic                                 clk1,
    input  logic                                 rst_n,
    input  logic                                 alloc_valid,
    input  logic [REG_W-1:0]                     alloc_dest,
    input  logic                                 alloc_is_branch,
    output logic                                 alloc_ready,
    output logic [$clog2(DEPTH)-1:0]             alloc_tag,
    input  logic [CDB_PORTS-1:0]                 cdb_valid,
    input  logic [CDB_PORTS*$clog2(DEPTH)-1:0]   cdb_tag,
    input  logic [CDB_PORTS*DATA_W-1:0]          cdb_value,
    input  logic [CDB_PORTS-1:0]                 cdb_mispredict,
    input  logic [$clog2(DEPTH)-1:0]             rd_tag_a,
    input  logic [$clog2(DEPTH)-1:0]             rd_tag_b,
    output logic                                 rd_ready_a,
    output logic                                 rd_ready_b,
    output logic [DATA_W-1:0]                    rd_value_a,
    output logic [DATA_W-1:0]                    rd_value_b,
    output logic                                 commit_valid,
    output logic [$clog2(DEPTH)-1:0]             commit_tag,
    output logic [REG_W-1:0]                     commit_dest,
    output logic [DATA_W-1:0]                    commit_value,
    output logic                                 commit_flush,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic                                 full,
    output logic                                 empty
);

    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rob_flags_t         flags_q [DEPTH];
    rob_flags_t         flags_d [DEPTH];
    logic [REG_W-1:0]   dest_q  [DEPTH];
    logic [REG_W-1:0]   dest_d  [DEPTH];
    logic [DATA_W-1:0]  value_q [DEPTH];
    logic [DATA_W-1:0]  value_d [DEPTH];
    logic [TAG_W-1:0]   head_q, head_d;
    logic [TAG_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               alloc_fire;

    // One matcher per entry for writeback capture.
    logic [DEPTH-1:0]   wb_hit;
    logic [DEPTH-1:0]   wb_mis;
    logic [DATA_W-1:0]  wb_value [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_wb
        tomasulo_cdb_match #(
            .TAG_W     (TAG_W),
            .DATA_W    (DATA_W),
            .CDB_PORTS (CDB_PORTS)
        ) u_wb_match (
            .tag            (TAG_W'(g)),
            .cdb_valid      (cdb_valid),
            .cdb_tag        (cdb_tag),
            .cdb_value      (cdb_value),
            .cdb_mispredict (cdb_mispredict),
            .hit_c          (wb_hit[g]),
            .value_c        (wb_value[g]),
            .mispredict_c   (wb_mis[g])
        );
    end

    // Read-port bypass matchers; mispredict is irrelevant to operands.
    logic               rda_hit, rdb_hit;
    logic [DATA_W-1:0]  rda_cdb_value, rdb_cdb_value;
    logic               rda_mis_unused, rdb_mis_unused;

    tomasulo_cdb_match #(
        .TAG_W     (TAG_W),
        .DATA_W    (DATA_W),
        .CDB_PORTS (CDB_PORTS)
    ) u_rda_match (
        .tag            (rd_tag_a),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .cdb_mispredict (cdb_mispredict),
        .hit_c          (rda_hit),
        .value_c        (rda_cdb_value),
        .mispredict_c   (rda_mis_unused)
    );

    tomasulo_cdb_match #(
        .TAG_W     (TAG_W),
        .DATA_W    (DATA_W),
        .CDB_PORTS (CDB_PORTS)
    ) u_rdb_match (
        .tag            (rd_tag_b),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .cdb_mispredict (cdb_mispredict),
        .hit_c          (rdb_hit),
        .value_c        (rdb_cdb_value),
        .mispredict_c   (rdb_mis_unused)
    );

    // Status, commit and allocation handshake, all derived from current state.
    always_comb begin
        count        = count_q;
        full         = (count_q == CNT_W'(DEPTH));
        empty        = (count_q == '0);
        alloc_tag    = tail_q;
        commit_valid = flags_q[head_q].busy && flags_q[head_q].ready;
        commit_flush = commit_valid && flags_q[head_q].is_branch
                       && flags_q[head_q].mispredict;
        commit_tag   = head_q;
        commit_dest  = commit_valid ? dest_q[head_q]  : '0;
        commit_value = commit_valid ? value_q[head_q] : '0;
        // A full buffer stays closed even while the head retires.
        alloc_ready  = !full && !commit_flush;
        alloc_fire   = alloc_valid && alloc_ready;
    end

    // Operand lookup: live CDB result first, then a completed entry.
    always_comb begin
        rd_ready_a = 1'b0;
        rd_value_a = '0;
        if (rda_hit) begin
            rd_ready_a = 1'b1;
            rd_value_a = rda_cdb_value;
        end else if (flags_q[rd_tag_a].busy && flags_q[rd_tag_a].ready) begin
            rd_ready_a = 1'b1;
            rd_value_a = value_q[rd_tag_a];
        end
    end

    always_comb begin
        rd_ready_b = 1'b0;
        rd_value_b = '0;
        if (rdb_hit) begin
            rd_ready_b = 1'b1;
            rd_value_b = rdb_cdb_value;
        end else if (flags_q[rd_tag_b].busy && flags_q[rd_tag_b].ready) begin
            rd_ready_b = 1'b1;
            rd_value_b = value_q[rd_tag_b];
        end
    end

    // Next state: capture, then commit, then allocate; a flush overrides all.
    always_comb begin
        flags_d = flags_q;
        dest_d  = dest_q;
        value_d = value_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wb_hit[i] && flags_q[i].busy && !flags_q[i].ready) begin
                flags_d[i].ready      = 1'b1;
                flags_d[i].mispredict = wb_mis[i] && flags_q[i].is_branch;
                value_d[i]            = wb_value[i];
            end
        end

        if (commit_valid) begin
            flags_d[head_q] = '0;
            head_d          = head_q + 1'b1;
        end

        if (alloc_fire) begin
            flags_d[tail_q] = '{busy: 1'b1, ready: 1'b0,
                                is_branch: alloc_is_branch, mispredict: 1'b0};
            dest_d[tail_q]  = alloc_dest;
            tail_d          = tail_q + 1'b1;
        end

        unique case ({alloc_fire, commit_valid})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (commit_flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                flags_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                flags_q[i] <= '0;
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            flags_q <= flags_d;
            dest_q  <= dest_d;
            value_q <= value_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_tomasulo_rob.sv
// Self-checking bench for tomasulo_rob: a directed vector table, hand-written
// multi-cycle sequences, and random traffic checked against a queue model.
module tb_tomasulo_rob;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned REG_W     = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CDB_PORTS = 2;
    localparam int unsigned TAG_W     = 3;
    localparam int unsigned CNT_W     = 4;

    logic                 clk1 = 1'b0;
    logic                 rst_n;
    logic                 av;
    logic [REG_W-1:0]     ad;
    logic                 ab;
    logic [CDB_PORTS-1:0] cv;
    logic [TAG_W-1:0]     ct   [CDB_PORTS];
    logic [DATA_W-1:0]    cval [CDB_PORTS];
    logic [CDB_PORTS-1:0] cm;
    logic [TAG_W-1:0]     rta, rtb;

    logic [CDB_PORTS*TAG_W-1:0]  cdb_tag;
    logic [CDB_PORTS*DATA_W-1:0] cdb_value;
    assign cdb_tag   = {ct[1], ct[0]};
    assign cdb_value = {cval[1], cval[0]};

    logic                 alloc_ready, rd_ready_a, rd_ready_b;
    logic [TAG_W-1:0]     alloc_tag, commit_tag;
    logic [DATA_W-1:0]    rd_value_a, rd_value_b, commit_value;
    logic                 commit_valid, commit_flush, full, empty;
    logic [REG_W-1:0]     commit_dest;
    logic [CNT_W-1:0]     count;

    tomasulo_rob #(
        .DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(DATA_W), .CDB_PORTS(CDB_PORTS)
    ) dut (
        .clk1(clk1), .rst_n(rst_n),
        .alloc_valid(av), .alloc_dest(ad), .alloc_is_branch(ab),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cv), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_mispredict(cm),
        .rd_tag_a(rta), .rd_tag_b(rtb),
        .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
        .rd_value_a(rd_value_a), .rd_value_b(rd_value_b),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_dest(commit_dest), .commit_value(commit_value),
        .commit_flush(commit_flush),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk1 = ~clk1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: program-order queue ----------------
    typedef struct {
        int          tag;
        int          dest;
        bit          br;
        bit          rdy;
        logic [31:0] val;
        bit          mis;
    } m_ent_t;

    m_ent_t mq[$];
    int     m_tail;

    function automatic int m_find(input int t);
        for (int i = 0; i < mq.size(); i++) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic void m_read(input int t, output bit r, output logic [31:0] v);
        int hitp = -1;
        int idx;
        r = 0;
        v = '0;
        for (int p = 0; p < CDB_PORTS; p++)
            if (hitp < 0 && cv[p] && int'(ct[p]) == t) hitp = p;
        if (hitp >= 0) begin
            r = 1;
            v = cval[hitp];
        end else begin
            idx = m_find(t);
            if (idx >= 0 && mq[idx].rdy) begin
                r = 1;
                v = mq[idx].val;
            end
        end
    endfunction

    task automatic check_all();
        bit          ecv, efl, er;
        logic [31:0] ev;
        int          n = mq.size();
        ecv = (n > 0) && mq[0].rdy;
        efl = ecv && mq[0].br && mq[0].mis;
        chk("count", count, n);
        chk("full", full, n == DEPTH);
        chk("empty", empty, n == 0);
        chk("alloc_ready", alloc_ready, (n < DEPTH) && !efl);
        chk("alloc_tag", alloc_tag, m_tail);
        chk("commit_valid", commit_valid, ecv);
        if (ecv) begin
            chk("commit_tag", commit_tag, mq[0].tag);
            chk("commit_dest", commit_dest, mq[0].dest);
            chk("commit_value", commit_value, mq[0].val);
            chk("commit_flush", commit_flush, efl);
        end
        m_read(int'(rta), er, ev);
        chk("rd_ready_a", rd_ready_a, er);
        if (er) chk("rd_value_a", rd_value_a, ev);
        m_read(int'(rtb), er, ev);
        chk("rd_ready_b", rd_ready_b, er);
        if (er) chk("rd_value_b", rd_value_b, ev);
    endtask

    task automatic m_update();
        bit     ecv, efl, aok;
        int     idx;
        m_ent_t e;
        ecv = (mq.size() > 0) && mq[0].rdy;
        efl = ecv && mq[0].br && mq[0].mis;
        aok = (mq.size() < DEPTH) && !efl;
        if (efl) begin
            mq.delete();
            m_tail = 0;
            return;
        end
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cv[p]) begin
                idx = m_find(int'(ct[p]));
                if (idx >= 0 && !mq[idx].rdy) begin
                    mq[idx].rdy = 1;
                    mq[idx].val = cval[p];
                    mq[idx].mis = cm[p] && mq[idx].br;
                end
            end
        end
        if (ecv) void'(mq.pop_front());
        if (av && aok) begin
            e.tag = m_tail; e.dest = int'(ad); e.br = ab;
            e.rdy = 0; e.val = '0; e.mis = 0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    // ---------------- drive helpers ----------------
    task automatic idle();
        av = 0; ad = '0; ab = 0; cv = '0; cm = '0;
        for (int p = 0; p < CDB_PORTS; p++) begin ct[p] = '0; cval[p] = '0; end
    endtask

    task automatic set_cdb(input int p, input int t, input logic [31:0] v, input bit m);
        cv[p] = 1'b1; ct[p] = TAG_W'(t); cval[p] = v; cm[p] = m;
    endtask

    task automatic alloc(input int d, input bit br);
        av = 1; ad = REG_W'(d); ab = br;
    endtask

    // Model-checked clock cycle: check outputs, clock, advance the model.
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk1);
        m_update();
        #1;
    endtask

    task automatic reset_dut();
        idle();
        rst_n = 0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_tag", commit_tag, 0);
        chk("rst_commit_dest", commit_dest, 0);
        chk("rst_commit_value", commit_value, 0);
        chk("rst_commit_flush", commit_flush, 0);
        chk("rst_rd_ready_a", rd_ready_a, 0);
        chk("rst_rd_ready_b", rd_ready_b, 0);
        chk("rst_rd_value_a", rd_value_a, 0);
        chk("rst_rd_value_b", rd_value_b, 0);
        @(posedge clk1);
        #1;
        rst_n = 1;
        mq.delete();
        m_tail = 0;
    endtask

    function automatic logic [TAG_W-1:0] pick_tag();
        if (mq.size() > 0 && $urandom_range(0, 9) < 8)
            return TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
        return TAG_W'($urandom_range(0, DEPTH - 1));
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          av;
        int          ad;
        bit [1:0]    cvb;
        int          t0, t1;
        logic [31:0] v0, v1;
        int          rta;
        int          e_tag;
        bit          e_ardy;
        int          e_cnt;
        bit          e_full, e_empty, e_cv;
        int          e_cdest;
        logic [31:0] e_cval;
        bit          e_rrdy;
        logic [31:0] e_rval;
    } vec_t;

    vec_t vt[13];
    int   exp_order[8] = '{3, 4, 5, 6, 7, 0, 1, 2};
    int   commits[$];

    initial begin
        rst_n = 1;
        idle();
        rta = '0;
        rtb = '0;
        #2;
        reset_dut();

        // Fill with dest 1..8, complete tag 0 via port 1, dual write on tag 3.
        for (int i = 0; i < 8; i++)
            vt[i] = '{1, i + 1, 2'b00, 0, 0, 0, 0, 7,
                      i, 1, i, 0, (i == 0), 0, 0, 0, 0, 0};
        vt[8]  = '{0, 0, 2'b10, 0, 0, 0, 32'h55, 0,
                   0, 0, 8, 1, 0, 0, 0, 0, 1, 32'h55};
        vt[9]  = '{0, 0, 2'b11, 3, 3, 32'h11, 32'h22, 0,
                   0, 0, 8, 1, 0, 1, 1, 32'h55, 1, 32'h55};
        vt[10] = '{0, 0, 2'b01, 3, 0, 32'h33, 0, 1,
                   0, 1, 7, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{0, 0, 2'b00, 0, 0, 0, 0, 3,
                   0, 1, 7, 0, 0, 0, 0, 0, 1, 32'h11};
        vt[12] = '{0, 0, 2'b00, 0, 0, 0, 0, 0,
                   0, 1, 7, 0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            idle();
            av = vt[i].av; ad = REG_W'(vt[i].ad);
            cv = vt[i].cvb;
            ct[0] = TAG_W'(vt[i].t0); ct[1] = TAG_W'(vt[i].t1);
            cval[0] = vt[i].v0; cval[1] = vt[i].v1;
            rta = TAG_W'(vt[i].rta);
            #1;
            chk("vec_alloc_tag", alloc_tag, vt[i].e_tag);
            chk("vec_alloc_ready", alloc_ready, vt[i].e_ardy);
            chk("vec_count", count, vt[i].e_cnt);
            chk("vec_full", full, vt[i].e_full);
            chk("vec_empty", empty, vt[i].e_empty);
            chk("vec_commit_valid", commit_valid, vt[i].e_cv);
            if (vt[i].e_cv) begin
                chk("vec_commit_dest", commit_dest, vt[i].e_cdest);
                chk("vec_commit_value", commit_value, vt[i].e_cval);
            end
            chk("vec_rd_ready_a", rd_ready_a, vt[i].e_rrdy);
            if (vt[i].e_rrdy) chk("vec_rd_value_a", rd_value_a, vt[i].e_rval);
            @(posedge clk1);
            #1;
        end

        // Wrap-around: retire 3, allocate 3 more, drain in program order.
        reset_dut();
        for (int i = 0; i < 8; i++) begin idle(); alloc(i + 1, 0); cycle(); end
        idle(); set_cdb(0, 0, 32'h100, 0); set_cdb(1, 1, 32'h101, 0); cycle();
        idle(); set_cdb(0, 2, 32'h102, 0); cycle();
        idle(); cycle();
        idle(); cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); alloc(9 + i, 0);
            #1;
            chk("wrap_alloc_tag", alloc_tag, i);
            cycle();
        end
        commits.delete();
        for (int k = 0; k < 20; k++) begin
            idle();
            if (k < 8) set_cdb(1, (3 + k) % 8, 32'h200 + k, 0);
            #1;
            if (commit_valid) commits.push_back(int'(commit_tag));
            cycle();
        end
        chk("wrap_commit_count", commits.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("wrap_commit_order", (i < commits.size()) ? commits[i] : -1, exp_order[i]);

        // Mispredicted branch at tag 2 with younger tags 3..5 in flight.
        reset_dut();
        for (int i = 0; i < 6; i++) begin idle(); alloc(i + 1, i == 2); cycle(); end
        idle(); set_cdb(0, 0, 32'h1, 0); set_cdb(1, 1, 32'h2, 0); cycle();
        idle(); set_cdb(0, 2, 32'h3, 1); set_cdb(1, 4, 32'h4, 0); cycle();
        idle(); cycle();
        idle(); alloc(15, 0);
        #1;
        chk("flush_commit_valid", commit_valid, 1);
        chk("flush_commit_tag", commit_tag, 2);
        chk("flush_flag", commit_flush, 1);
        chk("flush_alloc_ready", alloc_ready, 0);
        cycle();
        idle(); rta = 3;
        #1;
        chk("post_flush_count", count, 0);
        chk("post_flush_empty", empty, 1);
        chk("post_flush_alloc_tag", alloc_tag, 0);
        chk("post_flush_rd_ready", rd_ready_a, 0);
        cycle();

        // Same-cycle CDB bypass to a read port.
        reset_dut();
        for (int i = 0; i < 5; i++) begin idle(); alloc(i + 1, 0); cycle(); end
        idle(); rta = 4; set_cdb(0, 4, 32'h9, 0);
        #1;
        chk("bypass_rd_ready_a", rd_ready_a, 1);
        chk("bypass_rd_value_a", rd_value_a, 32'h9);
        cycle();

        // Asynchronous reset in the middle of a fill.
        for (int i = 0; i < 3; i++) begin idle(); alloc(i + 1, 0); cycle(); end
        reset_dut();

        // Random traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            idle();
            if ($urandom_range(0, 9) < 7) alloc($urandom_range(0, 15), $urandom_range(0, 4) == 0);
            for (int p = 0; p < CDB_PORTS; p++)
                if ($urandom_range(0, 9) < 5)
                    set_cdb(p, int'(pick_tag()), $urandom, $urandom_range(0, 9) == 0);
            rta = pick_tag();
            rtb = pick_tag();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
